// File: rtl/vga_pattern_gen.sv
// Test-pattern colour stage behind the 640x480 VGA timing generator.
// Two-stage pipeline; syncs and DE travel with the colour so all outputs stay aligned.
module vga_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int BOX_SIZE = 32,
    parameter int STEP     = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        hsync_i,
    input  logic        vsync_i,
    input  logic        pix_vld_i,
    input  logic [9:0]  hcnt_i,
    input  logic [9:0]  vcnt_i,
    input  logic [1:0]  mode_i,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        de_o,
    output logic [11:0] rgb_o
);
    localparam int STAGES = 2;
    localparam logic [10:0] X_LIM = 11'(H_ACTIVE - BOX_SIZE);
    localparam logic [10:0] Y_LIM = 11'(V_ACTIVE - BOX_SIZE);
    localparam logic [10:0] STP   = 11'(STEP);
    localparam logic [10:0] BOX_W = 11'(BOX_SIZE);

    // Returns {dir_neg_next, pos_next}; 11-bit sums so the edge tests never wrap.
    function automatic logic [10:0] bounce(input logic [9:0] pos, input logic neg,
                                           input logic [10:0] lim);
        logic [10:0] p;
        p = {1'b0, pos};
        if (!neg) begin
            if (p + STP >= lim) return {1'b1, lim[9:0]};
            else                return {1'b0, 10'(p + STP)};
        end else begin
            if (p <= STP) return {1'b0, 10'd0};
            else          return {1'b1, 10'(p - STP)};
        end
    endfunction

    logic        vsync_prev, tick;
    logic [1:0]  mode_q;
    logic [9:0]  box_x, box_y;
    logic        dir_x_neg, dir_y_neg;
    logic [10:0] bx_nxt, by_nxt;
    logic        inbox;

    logic [STAGES:1] vld_pipe, hs_pipe, vs_pipe;
    logic [9:0]  x_s1;
    logic        y5_s1;
    logic [1:0]  mode_s1;
    logic        inbox_s1;
    logic [11:0] colour, rgb_q;

    assign tick   = vsync_prev & ~vsync_i;
    assign bx_nxt = bounce(box_x, dir_x_neg, X_LIM);
    assign by_nxt = bounce(box_y, dir_y_neg, Y_LIM);

    always_comb begin
        inbox = ({1'b0, hcnt_i} >= {1'b0, box_x}) && ({1'b0, hcnt_i} < {1'b0, box_x} + BOX_W) &&
                ({1'b0, vcnt_i} >= {1'b0, box_y}) && ({1'b0, vcnt_i} < {1'b0, box_y} + BOX_W);
    end

    // Frame-rate state: mode and box only move on the vsync falling edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vsync_prev <= 1'b1;
            mode_q     <= 2'd0;
            box_x      <= '0;
            box_y      <= '0;
            dir_x_neg  <= 1'b0;
            dir_y_neg  <= 1'b0;
        end else begin
            vsync_prev <= vsync_i;
            if (tick) begin
                mode_q    <= mode_i;
                box_x     <= bx_nxt[9:0];
                dir_x_neg <= bx_nxt[10];
                box_y     <= by_nxt[9:0];
                dir_y_neg <= by_nxt[10];
            end
        end
    end

    always_comb begin
        colour = 12'h000;
        case (mode_s1)
            2'd0: begin
                if      (x_s1 < 10'd80)  colour = 12'hFFF;
                else if (x_s1 < 10'd160) colour = 12'hFF0;
                else if (x_s1 < 10'd240) colour = 12'h0FF;
                else if (x_s1 < 10'd320) colour = 12'h0F0;
                else if (x_s1 < 10'd400) colour = 12'hF0F;
                else if (x_s1 < 10'd480) colour = 12'hF00;
                else if (x_s1 < 10'd560) colour = 12'h00F;
                else                     colour = 12'h000;
            end
            2'd1:    colour = (x_s1[5] ^ y5_s1) ? 12'hFFF : 12'h000;
            2'd2:    colour = {3{x_s1[8:5]}};
            default: colour = inbox_s1 ? 12'h0F0 : 12'h008;
        endcase
    end

    // Mode is captured alongside the pixel so a tick never recolours an in-flight pixel.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_pipe <= '0;
            hs_pipe  <= '1;
            vs_pipe  <= '1;
            x_s1     <= '0;
            y5_s1    <= 1'b0;
            mode_s1  <= 2'd0;
            inbox_s1 <= 1'b0;
            rgb_q    <= 12'h000;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], pix_vld_i};
            hs_pipe  <= {hs_pipe[STAGES-1:1], hsync_i};
            vs_pipe  <= {vs_pipe[STAGES-1:1], vsync_i};
            x_s1     <= hcnt_i;
            y5_s1    <= vcnt_i[5];
            mode_s1  <= mode_q;
            inbox_s1 <= inbox;
            rgb_q    <= vld_pipe[1] ? colour : 12'h000;
        end
    end

    assign hsync_o = hs_pipe[STAGES];
    assign vsync_o = vs_pipe[STAGES];
    assign de_o    = vld_pipe[STAGES];
    assign rgb_o   = rgb_q;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// Randomised scoreboard bench for vga_pattern_gen: a frame-level reference model
// queues the expected output per input cycle and a monitor checks it two cycles on.
module tb_vga_pattern_gen;
    localparam int H = 640, V = 480, BOX = 32, STEP = 4;

    logic        clk_i = 1'b0;
    logic        rst_i, hsync_i, vsync_i, pix_vld_i;
    logic [9:0]  hcnt_i, vcnt_i;
    logic [1:0]  mode_i;
    logic        hsync_o, vsync_o, de_o;
    logic [11:0] rgb_o;

    vga_pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .BOX_SIZE(BOX), .STEP(STEP)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
        .pix_vld_i(pix_vld_i), .hcnt_i(hcnt_i), .vcnt_i(vcnt_i), .mode_i(mode_i),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o), .rgb_o(rgb_o)
    );

    always #20 clk_i = ~clk_i;

    typedef struct { int stamp; logic [14:0] exp; } item_t;
    item_t q[$];
    int cyc = 0;
    int n_chk = 0, n_err = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Reference model state: frame ticks since reset, latched mode, previous vsync.
    int   m_n = 0, m_mode = 0;
    logic m_vprev = 1'b1;
    logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};

    // Box travel is a triangle wave over tick count between 0 and lim.
    function automatic int tri_pos(int n, int lim);
        int per, p;
        per = 2 * lim / STEP;
        p   = n % per;
        return STEP * ((p <= per / 2) ? p : per - p);
    endfunction

    function automatic logic [11:0] ref_rgb(int md, int x, int y, int n);
        int bx, by, l;
        logic [3:0] v;
        bx = tri_pos(n, H - BOX);
        by = tri_pos(n, V - BOX);
        case (md)
            0: return bars[x / 80];
            1: return ((((x / 32) % 2) ^ ((y / 32) % 2)) != 0) ? 12'hFFF : 12'h000;
            2: begin l = (x / 32) % 16; v = 4'(l); return {v, v, v}; end
            default: return (x >= bx && x < bx + BOX && y >= by && y < by + BOX) ? 12'h0F0 : 12'h008;
        endcase
    endfunction

    task automatic drive(input logic r, input logic hs, input logic vs, input logic vld,
                         input int x, input int y, input int md);
        item_t it;
        @(posedge clk_i); #1;
        rst_i = r; hsync_i = hs; vsync_i = vs; pix_vld_i = vld;
        hcnt_i = 10'(x); vcnt_i = 10'(y); mode_i = 2'(md);
        it.stamp = cyc;
        if (r) begin
            it.exp = {1'b1, 1'b1, 1'b0, 12'h000};
            // The reset edge also clears whatever was about to emerge.
            if (q.size() > 0 && q[$].stamp == cyc - 1) q[$].exp = {1'b1, 1'b1, 1'b0, 12'h000};
            m_n = 0; m_mode = 0; m_vprev = 1'b1;
        end else begin
            it.exp = {hs, vs, vld, vld ? ref_rgb(m_mode, x, y, m_n) : 12'h000};
            if (m_vprev && !vs) begin
                m_mode = md;
                m_n++;
            end
            m_vprev = vs;
        end
        q.push_back(it);
    endtask

    task automatic tick(input int md);
        drive(0, 1, 0, 0, 0, 0, md);
        drive(0, 1, 1, 0, 0, 0, md);
    endtask

    always @(posedge clk_i) begin
        item_t it;
        #2;
        while (q.size() > 0 && q[0].stamp + 2 <= cyc) begin
            it = q.pop_front();
            n_chk++;
            if ({hsync_o, vsync_o, de_o, rgb_o} !== it.exp) begin
                n_err++;
                $display("FAIL out_vec stamp=%0d got hs/vs/de/rgb=%b/%b/%b/%h exp=%b/%b/%b/%h",
                         it.stamp, hsync_o, vsync_o, de_o, rgb_o,
                         it.exp[14], it.exp[13], it.exp[12], it.exp[11:0]);
            end
        end
    end

    initial begin
        int x, y, md;
        rst_i = 1'b1; hsync_i = 1'b1; vsync_i = 1'b1; pix_vld_i = 1'b0;
        hcnt_i = '0; vcnt_i = '0; mode_i = '0;
        repeat (3) drive(1, 1, 1, 0, 0, 0, 0);

        // Bars, including the last pixel and blanking with a live coordinate.
        drive(0, 1, 1, 1, 85, 10, 0);
        drive(0, 1, 1, 1, 639, 10, 0);
        drive(0, 1, 1, 0, 85, 10, 0);
        drive(0, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 79, 3, 0);
        drive(0, 1, 1, 1, 80, 3, 0);

        // Mid-frame mode change is held off until the next tick.
        drive(0, 1, 1, 1, 32, 0, 1);
        drive(0, 1, 1, 1, 32, 32, 1);
        tick(1);
        drive(0, 1, 1, 1, 32, 0, 1);
        drive(0, 1, 1, 1, 32, 32, 1);
        drive(0, 1, 1, 1, 0, 0, 1);
        tick(2);
        drive(0, 1, 1, 1, 511, 7, 2);
        drive(0, 1, 1, 1, 512, 7, 2);

        // Bouncing box to its right/bottom limits and back.
        drive(1, 1, 1, 0, 0, 0, 3);
        for (int t = 1; t <= 153; t++) begin
            tick(3);
            y = tri_pos(t, V - BOX);
            x = tri_pos(t, H - BOX);
            if (t == 112 || t == 151 || t == 152 || t == 153) begin
                drive(0, 1, 1, 1, x, y, 3);
                drive(0, 1, 1, 1, x - 1, y, 3);
                drive(0, 1, 1, 1, x + BOX - 1, y + BOX - 1, 3);
                drive(0, 1, 1, 1, x + BOX, y, 3);
                drive(0, 1, 1, 1, x, y + BOX, 3);
                drive(0, 1, 1, 1, 610, 450, 3);
                drive(0, 1, 1, 1, 607, 450, 3);
            end
        end
        // Tick coinciding with an active pixel: pre-update mode and box apply.
        drive(0, 1, 0, 1, 300, 200, 0);
        drive(0, 1, 1, 1, 300, 200, 0);

        // Reset mid-frame with the box at (100,100).
        drive(1, 1, 1, 0, 0, 0, 3);
        for (int t = 0; t < 25; t++) tick(3);
        drive(0, 1, 1, 1, 100, 100, 3);
        drive(1, 0, 1, 1, 100, 100, 3);
        drive(0, 1, 1, 1, 10, 10, 3);
        drive(0, 1, 1, 1, 100, 100, 3);
        tick(3);
        drive(0, 1, 1, 1, 0, 0, 3);
        drive(0, 1, 1, 1, 100, 100, 3);

        // Random frames: random pixels, syncs, mode requests and occasional resets.
        for (int f = 0; f < 60; f++) begin
            for (int k = 0; k < 12; k++) begin
                x  = int'($urandom_range(0, H - 1));
                y  = int'($urandom_range(0, V - 1));
                md = int'($urandom_range(0, 3));
                drive(($urandom_range(0, 79) == 0), ($urandom_range(0, 7) != 0), 1'b1,
                      ($urandom_range(0, 3) != 0), x, y, md);
            end
            tick(int'($urandom_range(0, 3)));
        end
        drive(0, 1, 1, 0, 0, 0, 0);

        repeat (4) @(posedge clk_i);
        #5;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
